uart_cmd_ctrl: RTL

Command-frame controller that sits directly behind the UART receiver and sequences its byte stream into register-bus writes. It hunts for a sync byte, collects address, length and payload into an internal buffer, and verifies an XOR checksum. Only then does it replay the payload as a burst of single-cycle writes to consecutive addresses. An inter-byte timeout recovers from truncated frames so a broken link never wedges the controller.

---
 rtl/uart_cmd_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frames UART bytes (sync, addr, len, payload, xor checksum) into register-bus write bursts
module uart_cmd_ctrl #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20,
  parameter int MAX_LEN      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);
  localparam int TIMEOUT_CYC = TIMEOUT_BITS * (CLK_FREQ / BAUD);
  localparam int GW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] SYNC = 8'hA5;
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CHK, WRITE} state_t;
  state_t state;
  logic [GW-1:0] gap;
  logic [7:0] idx, frame_len, base_addr, chk;
  logic [7:0] mem [MAX_LEN];
  always_ff @(posedge clk) begin
    wr_en <= 1'b0;
    frame_ok <= 1'b0;
    frame_err <= 1'b0;
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      err_code <= '0;
      gap <= '0;
      idx <= '0;
      frame_len <= '0;
      base_addr <= '0;
      chk <= '0;
    end else begin
      case (state)
        IDLE: if (rx_valid && rx_data == SYNC) begin
          state <= ADDR;
          busy <= 1'b1;
          gap <= '0;
        end
        // the first write is issued from CHK, so WRITE stays one cycle past the last write
        WRITE: if (idx == frame_len) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          wr_en <= 1'b1;
          wr_addr <= base_addr + idx;
          wr_data <= mem[idx[AW-1:0]];
          frame_ok <= idx == frame_len - 8'd1;
          idx <= idx + 8'd1;
        end
        default: if (rx_valid) begin
          gap <= '0;
          case (state)
            ADDR: begin
              base_addr <= rx_data;
              chk <= rx_data;
              state <= LEN;
            end
            LEN: if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
              frame_err <= 1'b1;
              err_code <= 2'd1;
              state <= IDLE;
              busy <= 1'b0;
            end else begin
              frame_len <= rx_data;
              chk <= chk ^ rx_data;
              idx <= '0;
              state <= DATA;
            end
            DATA: begin
              mem[idx[AW-1:0]] <= rx_data;
              chk <= chk ^ rx_data;
              idx <= idx + 8'd1;
              if (idx == frame_len - 8'd1) state <= CHK;
            end
            default: if (rx_data == chk) begin
              wr_en <= 1'b1;
              wr_addr <= base_addr;
              wr_data <= mem[0];
              frame_ok <= frame_len == 8'd1;
              idx <= 8'd1;
              state <= WRITE;
            end else begin
              frame_err <= 1'b1;
              err_code <= 2'd2;
              state <= IDLE;
              busy <= 1'b0;
            end
          endcase
        end else if (gap == GW'(TIMEOUT_CYC - 1)) begin
          frame_err <= 1'b1;
          err_code <= 2'd3;
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          gap <= gap + 1'b1;
        end
      endcase
    end
  end
endmodule
